// File: rtl/ecp5_pll_pkg.sv
// Shared types and constants for the ECP5 EHXPLLL dynamic-phase control slice.
package ecp5_pll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STEP_LO,
    STEP_HI,
    SETTLE,
    LOCKWAIT,
    DONE
  } pll_state_e;

  // EHXPLLL dynamic-phase pins are active-low pulses that idle high
  localparam logic PHASESTEP_IDLE    = 1'b1;
  localparam logic PHASELOADREG_IDLE = 1'b1;
  localparam logic PHASEDIR_RESET    = 1'b1;

  localparam logic [1:0] SEL_CLKOP  = 2'd0;
  localparam logic [1:0] SEL_CLKOS  = 2'd1;
  localparam logic [1:0] SEL_CLKOS2 = 2'd2;
  localparam logic [1:0] SEL_CLKOS3 = 2'd3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ecp5_pll_phase_ctrl_lock_filter.sv
// PLL LOCK conditioner: 2-FF synchroniser followed by a consecutive-high filter.
// Rises after LOCK_FILTER high samples, drops in the same cycle a low sample appears.
module pll_lock_filter #(
  parameter int unsigned LOCK_FILTER = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic lock_i,
  output logic locked_o
);

  localparam int unsigned CNT_W = $clog2(LOCK_FILTER + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LOCK_FILTER);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= lock_i;
      sync2_q <= sync1_q;
      if (!sync2_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_FULL) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign locked_o = sync2_q && (cnt_q == CNT_FULL);

endmodule

// File: rtl/ecp5_pll_phase_ctrl.sv
// ECP5 EHXPLLL dynamic-phase sequencer with filtered lock and timeout reporting.
// Optional per-channel phase accumulators are enabled with PLL_PHASE_TRACK_EN.
module ecp5_pll_phase_ctrl
  import ecp5_pll_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STEP_W        = 8,
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned PULSE_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_FILTER   = 8,
  parameter int unsigned LOCK_TIMEOUT  = 4096
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_chan,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  input  logic              pll_lock,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              phaseloadreg,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              locked_o
`ifdef PLL_PHASE_TRACK_EN
  ,
  input  logic                  phase_clr,
  output logic [CHANNELS*16-1:0] phase_acc
`endif
);

  localparam int unsigned CNT_MAX = max_u(max_u(SETUP_CYCLES, PULSE_CYCLES),
                                          max_u(SETTLE_CYCLES, LOCK_TIMEOUT));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_END   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_END   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_END  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(LOCK_TIMEOUT - 1);

  pll_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [1:0]        sel_q, sel_d;
  logic              dir_q, dir_d;
  logic              err_q, err_d;
  logic              req_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              phasestep_q;
  logic              locked;
  logic              chan_ok;

  pll_lock_filter #(
    .LOCK_FILTER (LOCK_FILTER)
  ) u_lock_filter (
    .clk_i    (clk),
    .rst_ni   (resetn),
    .lock_i   (pll_lock),
    .locked_o (locked)
  );

  assign chan_ok = (32'(req_chan) < CHANNELS);

  // Zero-step and rejected requests still take one SETUP cycle, so done lands
  // two cycles after accept and never overlaps a new handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SETUP;
          cnt_d   = '0;
          err_d   = !chan_ok;
          rem_d   = chan_ok ? req_steps : '0;
          if (chan_ok) begin
            sel_d = req_chan;
            dir_d = req_dir;
          end
        end
      end
      SETUP: begin
        if (rem_q == '0) begin
          state_d = DONE;
        end else if (cnt_q == SETUP_END) begin
          state_d = STEP_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STEP_LO: begin
        if (cnt_q == PULSE_END) begin
          state_d = STEP_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STEP_HI: begin
        if (cnt_q == PULSE_END) begin
          rem_d   = rem_q - 1'b1;
          state_d = (rem_d == '0) ? SETTLE : STEP_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_END) begin
          state_d = LOCKWAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCKWAIT: begin
        if (locked) begin
          state_d = DONE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_END) begin
          state_d = DONE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      sel_q       <= SEL_CLKOP;
      dir_q       <= PHASEDIR_RESET;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      phasestep_q <= PHASESTEP_IDLE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      sel_q       <= sel_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      req_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      phasestep_q <= (state_d == STEP_LO) ? ~PHASESTEP_IDLE : PHASESTEP_IDLE;
    end
  end

  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = phasestep_q;
  assign phaseloadreg = PHASELOADREG_IDLE;
  assign locked_o     = locked;

`ifdef PLL_PHASE_TRACK_EN
  logic        step_done;
  logic [15:0] acc_q [CHANNELS];

  assign step_done = (state_q == STEP_HI) && (cnt_q == PULSE_END);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
    end else if (phase_clr) begin
      for (int unsigned c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
    end else if (step_done) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (sel_q == 2'(c)) acc_q[c] <= acc_q[c] + (dir_q ? 16'h0001 : 16'hFFFF);
      end
    end
  end

  always_comb begin
    phase_acc = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) phase_acc[c*16 +: 16] = acc_q[c];
  end
`endif

endmodule

// File: tb/tb_ecp5_pll_phase_ctrl.sv
// Scoreboard bench for ecp5_pll_phase_ctrl (CHANNELS=3); optional PLL_PHASE_TRACK_EN checks.
module tb_ecp5_pll_phase_ctrl;

  logic       clk;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_chan;
  logic       req_dir;
  logic [7:0] req_steps;
  logic       pll_lock;
  logic [1:0] phasesel;
  logic       phasedir;
  logic       phasestep;
  logic       phaseloadreg;
  logic       busy;
  logic       done;
  logic       err;
  logic       locked_o;
`ifdef PLL_PHASE_TRACK_EN
  logic        phase_clr;
  logic [47:0] phase_acc;
`endif

  ecp5_pll_phase_ctrl #(
    .CHANNELS (3)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_chan     (req_chan),
    .req_dir      (req_dir),
    .req_steps    (req_steps),
    .pll_lock     (pll_lock),
    .phasesel     (phasesel),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .locked_o     (locked_o)
`ifdef PLL_PHASE_TRACK_EN
    ,
    .phase_clr    (phase_clr),
    .phase_acc    (phase_acc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         lat;
    bit         err_acc;
    bit         err_done;
    logic [1:0] sel;
    bit         dir;
    int         pulses;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic [1:0] cur_sel  = 2'd0;
  bit         cur_dir  = 1'b1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: checks accept-time outputs, pulse shape and done against the queue
  int acc_cyc   = 0;
  bit pend_acc  = 0;
  bit in_txn    = 0;
  bit post_done = 0;
  bit prev_step = 1;
  int pulses    = 0;
  int lowc      = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      pend_acc  = 0;
      in_txn    = 0;
      post_done = 0;
    end else begin
      if (post_done) begin
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("ready_after_done", req_ready, 1);
        post_done = 0;
      end
      if (pend_acc && sb_q.size() != 0) begin
        chk("sel_after_accept", phasesel, sb_q[0].sel);
        chk("dir_after_accept", phasedir, sb_q[0].dir);
        chk("err_after_accept", err, sb_q[0].err_acc);
        chk("busy_after_accept", busy, 1);
        pend_acc = 0;
      end
      if (in_txn) begin
        if (!phasestep) begin
          lowc++;
          if (prev_step) pulses++;
        end
        prev_step = phasestep;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("latency", cyc - acc_cyc, e.lat);
          chk("err_at_done", err, e.err_done);
          chk("sel_at_done", phasesel, e.sel);
          chk("dir_at_done", phasedir, e.dir);
          chk("pulse_count", pulses, e.pulses);
          chk("low_cycles", lowc, 4 * e.pulses);
        end
        in_txn    = 0;
        post_done = 1;
      end
      if (req_valid && req_ready) begin
        acc_cyc   = cyc;
        pend_acc  = 1;
        in_txn    = 1;
        pulses    = 0;
        lowc      = 0;
        prev_step = 1;
      end
    end
  end

  task automatic send(input logic [1:0] chan, input bit dir, input int steps, input bit tmo);
    exp_t e;
    bit   ok;
    int   n;
    ok = (chan < 2'd3);
    if (ok) begin
      cur_sel = chan;
      cur_dir = dir;
    end
    e.err_acc  = !ok;
    e.err_done = !ok || tmo;
    e.sel      = cur_sel;
    e.dir      = cur_dir;
    e.pulses   = ok ? steps : 0;
    e.lat      = (!ok || steps == 0) ? 2 : (2 + 8 * steps + 16 + (tmo ? 4096 : 1) + 1);
    sb_q.push_back(e);
    req_chan  = chan;
    req_dir   = dir;
    req_steps = 8'(steps);
    req_valid = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (req_ready) break;
    end
    chk("handshake_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    chk("sb_drain", sb_q.size(), 0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    resetn    = 1'b1;
    req_valid = 1'b0;
    req_chan  = 2'd0;
    req_dir   = 1'b0;
    req_steps = 8'd0;
    pll_lock  = 1'b1;
`ifdef PLL_PHASE_TRACK_EN
    phase_clr = 1'b0;
`endif
    #1 resetn = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_phasesel", phasesel, 0);
    chk("rst_phasedir", phasedir, 1);
    chk("rst_phasestep", phasestep, 1);
    chk("rst_loadreg", phaseloadreg, 1);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    n = 0;
    while (n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (locked_o) break;
    end
    chk("lock_rise_cycles", n, 10);
    @(posedge clk);
    #1;

    send(2'd2, 1'b1, 3, 1'b0);
    wait_done();
    send(2'd0, 1'b0, 0, 1'b0);
    wait_done();
    chk("err_zero_steps", err, 0);
    send(2'd3, 1'b1, 2, 1'b0);
    wait_done();
    chk("err_bad_chan_sticky", err, 1);

    send(2'd1, 1'b1, 1, 1'b1);
    pll_lock = 1'b0;
    wait_done();
    chk("err_timeout_sticky", err, 1);
    pll_lock = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("relock", locked_o, 1);
    send(2'd0, 1'b0, 2, 1'b0);
    wait_done();
    chk("err_cleared", err, 0);

    send(2'd2, 1'b1, 5, 1'b0);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (!phasestep) break;
    end
    chk("step_lo_reached", phasestep, 0);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_phasestep", phasestep, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_done", done, 0);
    sb_q.delete();
    cur_sel = 2'd0;
    cur_dir = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("postrst_ready", req_ready, 1);
    repeat (15) @(posedge clk);
    #1;
    chk("postrst_locked", locked_o, 1);

    send(2'd1, 1'b0, 3, 1'b0);
    wait_done();
`ifdef PLL_PHASE_TRACK_EN
    chk("acc_ch1", phase_acc[31:16], 16'hFFFD);
    chk("acc_ch0", phase_acc[15:0], 16'h0000);
    phase_clr = 1'b1;
    @(posedge clk);
    #1 phase_clr = 1'b0;
    chk("acc_clr", phase_acc[31:16], 16'h0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
